mem_write_arbiter: RTL and testbench

- Parametrised N-port write arbiter in the clk_ram domain that merges per-client burst streams into one MIG-style app_* write interface.
- Round-robin over enabled ports; grants only a port that has a full burst of data plus an address queued.
- Each burst is BURST_WORDS data beats followed by one write command; data always precedes the command.
- Successor to the fixed 2-port arbiter: generic port count, data/address width and burst length, per-port enable mask, correct stall handling on app_rdy and app_wdf_rdy, per-port burst counters.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mem_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_write_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - MIG command codes and FSM state type for the memory write arbiter
package mem_arb_pkg;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DATA,
        ARB_CMD
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting at a pointer, wrapping modulo NUM_REQ
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               hit
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = ptr;
        hit   = 1'b0;
        cand  = '0;
        // Walk from the farthest candidate back to ptr so the nearest requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                grant = cand;
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - N-port round-robin burst write arbiter driving a MIG-style app_* interface
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 29,
    parameter int BURST_WORDS = 2,
    parameter int CNT_WIDTH   = 10,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                            clk_ram,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            port_enable,
    input  logic [NUM_PORTS-1:0]            cmd_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] cmd_addr,
    output logic [NUM_PORTS-1:0]            cmd_ready,
    input  logic [NUM_PORTS*CNT_WIDTH-1:0]  data_words,
    input  logic [NUM_PORTS-1:0]            data_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data,
    output logic [NUM_PORTS-1:0]            data_ready,
    output logic [ADDR_WIDTH-1:0]           app_addr,
    output logic [2:0]                      app_cmd,
    output logic                            app_en,
    input  logic                            app_rdy,
    output logic [DATA_WIDTH-1:0]           app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]         app_wdf_mask,
    output logic                            app_wdf_wren,
    output logic                            app_wdf_end,
    input  logic                            app_wdf_rdy,
    output logic                            busy,
    output logic                            burst_done,
    output logic [NUM_PORTS*PERF_WIDTH-1:0] burst_count
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int WL_W  = $clog2(BURST_WORDS + 1);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       grant_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [WL_W-1:0]        words_left_q;
    logic [ADDR_WIDTH-1:0]  app_addr_q;
    logic                   app_en_q;
    logic [DATA_WIDTH-1:0]  wdf_data_q;
    logic                   wdf_wren_q;
    logic                   wdf_end_q;
    logic                   burst_done_q;
    logic [PERF_WIDTH-1:0]  count_q [NUM_PORTS];

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]   eligible;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign addr_arr[i] = cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
        assign eligible[i] = port_enable[i] & cmd_valid[i]
                           & (data_words[i*CNT_WIDTH +: CNT_WIDTH] >= CNT_WIDTH'(BURST_WORDS));
        assign burst_count[i*PERF_WIDTH +: PERF_WIDTH] = count_q[i];
    end

    logic [IDX_W-1:0] arb_grant;
    logic             arb_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .hit   (arb_hit)
    );

    logic data_ready_d;
    logic beat_load_d;
    logic end_accept_d;
    logic [IDX_W-1:0] rr_next_d;

    assign data_ready_d = (state_q == ARB_DATA) && (words_left_q != '0) && (!wdf_wren_q || app_wdf_rdy);
    assign beat_load_d  = data_ready_d && data_valid[grant_q];
    assign end_accept_d = wdf_wren_q && wdf_end_q && app_wdf_rdy;
    assign rr_next_d    = (arb_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : arb_grant + 1'b1;

    // The address pop is combinational in the grant cycle; gating with rst_n keeps it quiet during reset.
    assign cmd_ready  = (rst_n && (state_q == ARB_IDLE) && arb_hit) ? (NUM_PORTS'(1) << arb_grant) : '0;
    assign data_ready = data_ready_d ? (NUM_PORTS'(1) << grant_q) : '0;

    assign app_addr     = app_addr_q;
    assign app_cmd      = MIG_CMD_WRITE;
    assign app_en       = app_en_q;
    assign app_wdf_data = wdf_data_q;
    assign app_wdf_mask = '0;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_end_q;
    assign busy         = (state_q != ARB_IDLE);
    assign burst_done   = burst_done_q;

    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            words_left_q <= '0;
            app_addr_q   <= '0;
            app_en_q     <= 1'b0;
            wdf_data_q   <= '0;
            wdf_wren_q   <= 1'b0;
            wdf_end_q    <= 1'b0;
            burst_done_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            burst_done_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (arb_hit) begin
                        grant_q      <= arb_grant;
                        app_addr_q   <= addr_arr[arb_grant];
                        rr_ptr_q     <= rr_next_d;
                        words_left_q <= WL_W'(BURST_WORDS);
                        state_q      <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (beat_load_d) begin
                        wdf_data_q   <= data_arr[grant_q];
                        wdf_wren_q   <= 1'b1;
                        wdf_end_q    <= (words_left_q == WL_W'(1));
                        words_left_q <= words_left_q - 1'b1;
                    end else if (wdf_wren_q && app_wdf_rdy) begin
                        wdf_wren_q <= 1'b0;
                        wdf_end_q  <= 1'b0;
                    end
                    // Command goes out only after the last beat has been taken by the memory.
                    if (end_accept_d) begin
                        app_en_q <= 1'b1;
                        state_q  <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    if (app_rdy) begin
                        app_en_q          <= 1'b0;
                        burst_done_q      <= 1'b1;
                        count_q[grant_q]  <= count_q[grant_q] + 1'b1;
                        state_q           <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - self-checking bench with queue-based client and memory scoreboard model
module tb_mem_write_arbiter;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int AW = 29;
    localparam int BW = 2;
    localparam int CW = 10;
    localparam int PW = 32;

    logic              clk_ram = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     port_enable, cmd_valid, cmd_ready, data_valid, data_ready;
    logic [NP*AW-1:0]  cmd_addr;
    logic [NP*CW-1:0]  data_words;
    logic [NP*DW-1:0]  data;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic              app_en, app_rdy;
    logic [DW-1:0]     app_wdf_data;
    logic [DW/8-1:0]   app_wdf_mask;
    logic              app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic              busy, burst_done;
    logic [NP*PW-1:0]  burst_count;

    always #5 clk_ram = ~clk_ram;

    mem_write_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .BURST_WORDS(BW), .CNT_WIDTH(CW), .PERF_WIDTH(PW)
    ) dut (
        .clk_ram(clk_ram), .rst_n(rst_n), .port_enable(port_enable),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .data_words(data_words), .data_valid(data_valid), .data(data), .data_ready(data_ready),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .busy(busy), .burst_done(burst_done), .burst_count(burst_count)
    );

    // Client queues and memory-side expectations
    logic [DW-1:0] dq [NP][$];
    logic [AW-1:0] aq [NP][$];
    logic [DW-1:0] exp_beats [$];
    logic [AW-1:0] exp_addr;
    int m_rr, cur_g, done_g, m_cnt [NP];
    bit done_exp, first_beat_seen;
    int grant_log [$], grant_cyc [$], lat_log [$];
    logic [NP-1:0] en_knob, last_dr;
    int bubble_pct, stall_pct, wdf_hold, app_hold, dr_pops;
    int checks = 0, errors = 0, cyc = 0;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NP; k++) begin
            int p = (m_rr + k) % NP;
            if (en_knob[p] && aq[p].size() > 0 && dq[p].size() >= BW) return p;
        end
        return -1;
    endfunction

    task automatic push_burst(input int p);
        aq[p].push_back(AW'($urandom));
        for (int b = 0; b < BW; b++) dq[p].push_back(rand_word());
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            dq[i].delete(); aq[i].delete(); m_cnt[i] = 0;
        end
        exp_beats.delete(); grant_log.delete(); grant_cyc.delete(); lat_log.delete();
        m_rr = 0; cur_g = 0; done_g = 0; done_exp = 0; first_beat_seen = 1;
        en_knob = '1; bubble_pct = 0; stall_pct = 0; wdf_hold = 0; app_hold = 0; dr_pops = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            port_enable[i]         = en_knob[i];
            cmd_valid[i]           = aq[i].size() > 0;
            cmd_addr[i*AW +: AW]   = (aq[i].size() > 0) ? aq[i][0] : '0;
            data_words[i*CW +: CW] = CW'(dq[i].size());
            data_valid[i]          = (dq[i].size() > 0) && (int'($urandom_range(99)) >= bubble_pct);
            data[i*DW +: DW]       = (dq[i].size() > 0) ? dq[i][0] : '0;
        end
        app_wdf_rdy = (wdf_hold == 0) && (int'($urandom_range(99)) >= stall_pct);
        app_rdy     = (app_hold == 0) && (int'($urandom_range(99)) >= stall_pct);
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, score what the next rising edge commits.
    task automatic cycle();
        int eg, g;
        drive();
        #1;
        eg = exp_grant();
        last_dr = data_ready;
        checks++;
        if (burst_done !== done_exp) begin
            errors++; $display("FAIL burst_done: got %b expected %b at cycle %0d", burst_done, done_exp, cyc);
        end
        if (done_exp) begin
            checks++;
            if (burst_count[done_g*PW +: PW] !== PW'(m_cnt[done_g])) begin
                errors++; $display("FAIL burst_count[%0d]: got %0d expected %0d", done_g, burst_count[done_g*PW +: PW], m_cnt[done_g]);
            end
        end
        done_exp = 0;
        if (!busy) begin
            g = -1;
            for (int i = 0; i < NP; i++) if (cmd_ready[i]) g = (g == -1) ? i : -2;
            checks++;
            if (g != eg) begin
                errors++; $display("FAIL grant: got port %0d expected port %0d at cycle %0d", g, eg, cyc);
            end
            if (g >= 0 && aq[g].size() > 0 && dq[g].size() >= BW) begin
                m_rr = (g + 1) % NP; cur_g = g;
                exp_addr = aq[g].pop_front();
                exp_beats.delete();
                for (int b = 0; b < BW; b++) exp_beats.push_back(dq[g][b]);
                grant_log.push_back(g); grant_cyc.push_back(cyc); first_beat_seen = 0;
            end
        end else begin
            checks++;
            if (cmd_ready !== '0) begin
                errors++; $display("FAIL cmd_ready_busy: got %b expected 0", cmd_ready);
            end
        end
        if (data_ready !== '0) begin
            checks++;
            if (data_ready !== (NP'(1) << cur_g) || cmd_ready !== '0) begin
                errors++; $display("FAIL data_ready: got %b expected %b with cmd_ready %b", data_ready, NP'(1) << cur_g, cmd_ready);
            end
            dr_pops++;
            if (data_valid[cur_g] && dq[cur_g].size() > 0) void'(dq[cur_g].pop_front());
        end
        if (app_wdf_wren && !first_beat_seen && grant_cyc.size() > 0) begin
            first_beat_seen = 1; lat_log.push_back(cyc - grant_cyc[$]);
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            checks++;
            if (exp_beats.size() == 0) begin
                errors++; $display("FAIL beat_extra: got data %h expected no beat", app_wdf_data);
            end else begin
                if (app_wdf_data !== exp_beats[0] || app_wdf_end !== (exp_beats.size() == 1) || app_wdf_mask !== '0) begin
                    errors++; $display("FAIL beat: got %h end %b expected %h end %b", app_wdf_data, app_wdf_end, exp_beats[0], exp_beats.size() == 1);
                end
                void'(exp_beats.pop_front());
            end
        end
        if (app_en && app_rdy) begin
            checks++;
            if (app_addr !== exp_addr || app_cmd !== 3'b000 || exp_beats.size() != 0) begin
                errors++; $display("FAIL cmd: got addr %h cmd %b beats_left %0d expected addr %h cmd 000 beats_left 0", app_addr, app_cmd, exp_beats.size(), exp_addr);
            end
            m_cnt[cur_g]++; done_exp = 1; done_g = cur_g;
        end
        if (wdf_hold > 0) wdf_hold--;
        if (app_hold > 0) app_hold--;
        @(negedge clk_ram);
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        bit ok = 0;
        for (int n = 0; n < budget; n++) begin
            if (!busy && exp_grant() < 0 && !done_exp) begin ok = 1; break; end
            cycle();
        end
        if (!ok) begin
            checks++; errors++; $display("FAIL timeout_idle: got busy %b expected idle within %0d cycles", busy, budget);
        end
    endtask

    task automatic run_until_grants(input int n_grants, input int budget);
        for (int n = 0; n < budget && grant_log.size() < n_grants; n++) cycle();
        if (grant_log.size() < n_grants) begin
            checks++; errors++; $display("FAIL timeout_grants: got %0d grants expected %0d", grant_log.size(), n_grants);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive();
        repeat (2) @(negedge clk_ram);
        rst_n = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, busy, burst_done} !== 5'b0 || cmd_ready !== '0 || data_ready !== '0) begin
            errors++; $display("FAIL %s_ctrl: got en %b wren %b end %b busy %b done %b cmd_rdy %b data_rdy %b expected all 0", tag, app_en, app_wdf_wren, app_wdf_end, busy, burst_done, cmd_ready, data_ready);
        end
        checks++;
        if (app_addr !== '0 || app_wdf_data !== '0 || app_wdf_mask !== '0 || app_cmd !== 3'b000 || burst_count !== '0) begin
            errors++; $display("FAIL %s_data: got addr %h data %h count %h expected 0", tag, app_addr, app_wdf_data, burst_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        push_burst(1);
        drive();
        repeat (2) @(negedge clk_ram);
        #1;
        check_outputs_zero("reset");
        @(negedge clk_ram);
        rst_n = 1'b1;
        run_until_idle(30);
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 1 || burst_count[1*PW +: PW] !== 32'd1) begin
            errors++; $display("FAIL reset_first_burst: got %0d grants count %0d expected 1 grant of port 1", grant_log.size(), burst_count[1*PW +: PW]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) push_burst(p);
        run_until_idle(100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant_log.size() <= i || grant_log[i] != i % NP) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, (grant_log.size() > i) ? grant_log[i] : -1, i % NP);
            end
        end
        for (int i = 0; i < 4 && i + 1 < grant_cyc.size(); i++) begin
            checks++;
            if (grant_cyc[i+1] - grant_cyc[i] != BW + 3) begin
                errors++; $display("FAIL rr_burst_len[%0d]: got %0d cycles expected %0d", i, grant_cyc[i+1] - grant_cyc[i], BW + 3);
            end
        end
        for (int i = 0; i < lat_log.size(); i++) begin
            checks++;
            if (lat_log[i] != 2) begin
                errors++; $display("FAIL rr_latency[%0d]: got %0d expected 2", i, lat_log[i]);
            end
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (burst_count[p*PW +: PW] !== 32'd2) begin
                errors++; $display("FAIL rr_count[%0d]: got %0d expected 2", p, burst_count[p*PW +: PW]);
            end
        end
    endtask

    task automatic test_starved_port();
        do_reset();
        push_burst(1);
        run_until_idle(30);
        grant_log.delete();
        aq[2].push_back(AW'($urandom));
        dq[2].push_back(rand_word());
        push_burst(3);
        run_until_grants(1, 20);
        dq[2].push_back(rand_word());
        run_until_idle(40);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 2) begin
            errors++; $display("FAIL starved_order: got %0d grants first %0d expected ports 3 then 2", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_wdf_stall();
        logic [DW-1:0] hold_data;
        logic hold_end;
        bit armed = 0, in_stall;
        do_reset();
        push_burst(0);
        for (int n = 0; n < 15; n++) begin
            if (!armed && app_wdf_wren) begin
                armed = 1; wdf_hold = 3; hold_data = app_wdf_data; hold_end = app_wdf_end;
            end
            in_stall = wdf_hold > 0;
            if (in_stall) begin
                checks++;
                if (app_wdf_data !== hold_data || app_wdf_end !== hold_end || app_wdf_wren !== 1'b1) begin
                    errors++; $display("FAIL wdf_hold: got %h end %b expected %h end %b", app_wdf_data, app_wdf_end, hold_data, hold_end);
                end
            end
            cycle();
            if (in_stall) begin
                checks++;
                if (last_dr !== '0) begin
                    errors++; $display("FAIL wdf_stall_ready: got %b expected 0", last_dr);
                end
            end
        end
        checks++;
        if (!armed || dr_pops != BW || m_cnt[0] != 1) begin
            errors++; $display("FAIL wdf_stall_beats: got armed %0d pops %0d bursts %0d expected 1 %0d 1", armed, dr_pops, BW, m_cnt[0]);
        end
    endtask

    task automatic test_cmd_stall();
        bit armed = 0;
        int en_cycles = 0, dones = 0;
        do_reset();
        push_burst(2);
        for (int n = 0; n < 20; n++) begin
            if (!armed && app_en) begin armed = 1; app_hold = 4; end
            if (app_en) en_cycles++;
            if (burst_done) dones++;
            cycle();
        end
        checks++;
        if (!armed || en_cycles != 5 || dones != 1 || burst_count[2*PW +: PW] !== 32'd1) begin
            errors++; $display("FAIL cmd_stall: got en_cycles %0d dones %0d count %0d expected 5 1 1", en_cycles, dones, burst_count[2*PW +: PW]);
        end
    endtask

    task automatic test_enable_mask();
        do_reset();
        en_knob = 4'b0101;
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) push_burst(p);
        run_until_idle(80);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log.size() != 4 || grant_log[i] != ((i % 2) * 2)) begin
                errors++; $display("FAIL mask_order[%0d]: got %0d expected %0d", i, (grant_log.size() > i) ? grant_log[i] : -1, (i % 2) * 2);
            end
        end
        checks++;
        if (burst_count[1*PW +: PW] !== '0 || burst_count[3*PW +: PW] !== '0) begin
            errors++; $display("FAIL mask_disabled: got counts %0d %0d expected 0 0", burst_count[1*PW +: PW], burst_count[3*PW +: PW]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_burst(1);
        push_burst(2);
        for (int n = 0; n < 10 && !app_wdf_wren; n++) cycle();
        checks++;
        if (app_wdf_wren !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: got wren %b expected 1", app_wdf_wren);
        end
        drive();
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        @(negedge clk_ram);
        model_reset();
        drive();
        @(negedge clk_ram);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy);
        end
        push_burst(3);
        push_burst(0);
        run_until_idle(40);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
            errors++; $display("FAIL reset_mid_order: got %0d grants first %0d expected ports 0 then 3", grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
    endtask

    task automatic test_random();
        int p;
        do_reset();
        bubble_pct = 20;
        stall_pct  = 30;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(5) == 0) begin
                p = int'($urandom_range(NP - 1));
                if (aq[p].size() < 4) push_burst(p);
            end
            if ($urandom_range(9) == 0) en_knob = NP'($urandom);
            cycle();
        end
        en_knob = '1; bubble_pct = 0; stall_pct = 0;
        run_until_idle(600);
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (burst_count[i*PW +: PW] !== PW'(m_cnt[i]) || aq[i].size() != 0 || dq[i].size() != 0) begin
                errors++; $display("FAIL random_final[%0d]: got count %0d left %0d/%0d expected %0d 0/0", i, burst_count[i*PW +: PW], aq[i].size(), dq[i].size(), m_cnt[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive();
        @(negedge clk_ram);
        test_reset();
        test_round_robin();
        test_starved_port();
        test_wdf_stall();
        test_cmd_stall();
        test_enable_mask();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
